wb_arbiter_rr: RTL and testbench

Two-master, one-slave Wishbone (pipelined, with stall) arbiter. It shares a single-ported slave, such as a single-port memory or a peripheral bus segment, between two requesters, for example the core data port and a loader/DMA engine. Arbitration is round-robin with the grant held for a whole bus cycle. The block tracks outstanding requests, caps them, and aborts a hung slave with an error after a programmable timeout.

---
 rtl/wb_arb_defs.sv | 11 +
 rtl/wb_arbiter_rr_if.sv | 18 +
 rtl/wb_outst_tracker.sv | 34 +++
 rtl/wb_arbiter_rr.sv | 107 ++++++++++
 tb/tb_wb_arbiter_rr.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/wb_arb_defs.sv
// wb_arb_defs: shared state encodings and counter sizing for the round-robin Wishbone arbiter
package wb_arb_defs;
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN   = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_t;
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/wb_arbiter_rr_if.sv
// wb_arbiter_rr_if: one pipelined Wishbone link; master drives requests, slave drives responses
interface wb_arbiter_rr_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    stall;
  logic                    ack;
  logic                    err;
  logic [DATA_WIDTH-1:0]   dat_r;
  modport master (output cyc, stb, we, adr, dat_w, sel, input stall, ack, err, dat_r);
  modport slave  (input cyc, stb, we, adr, dat_w, sel, output stall, ack, err, dat_r);
endinterface

// File: rtl/wb_outst_tracker.sv
// wb_outst_tracker: outstanding-request counter with spurious-response filter and hung-slave timer
module wb_outst_tracker
  import wb_arb_defs::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clr,
  input  logic acc,
  input  logic rsp,
  output logic full,
  output logic rsp_ok,
  output logic to
);
  localparam int CW = cnt_width(MAX_OUTST);
  localparam int TW = cnt_width(TIMEOUT);
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tmr;
  assign rsp_ok = rsp & (cnt != '0);
  assign full   = cnt == CW'(MAX_OUTST);
  assign to     = (TIMEOUT != 0) && (tmr == TW'(TIMEOUT));
  assign cnt_n  = (acc & ~rsp_ok) ? cnt + 1'b1 : (~acc & rsp_ok) ? cnt - 1'b1 : cnt;
  // tmr holds the cycles elapsed since the last accept/ack while requests remain in flight
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i | clr) begin
      cnt <= '0;
      tmr <= '0;
    end else begin
      cnt <= cnt_n;
      tmr <= (TIMEOUT == 0 || cnt_n == '0) ? '0 : (acc | rsp_ok) ? TW'(1) : tmr + 1'b1;
    end
endmodule

// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr: two-master round-robin Wishbone arbiter with outstanding cap and slave timeout
module wb_arbiter_rr
  import wb_arb_defs::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTST  = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wb_arbiter_rr_if.slave         m0,
  wb_arbiter_rr_if.slave         m1,
  wb_arbiter_rr_if.master        s,
  output logic [1:0]             gnt_o,
  output logic                   timeout_o
);
  arb_state_t state, state_n;
  logic own, own_n, last, last_n;
  logic act, g0, g1, full, to, rsp_ok, clr;
  logic o_cyc, o_stb, o_we, oth_cyc;
  logic [ADDR_WIDTH-1:0]   o_adr;
  logic [DATA_WIDTH-1:0]   o_dat;
  logic [DATA_WIDTH/8-1:0] o_sel;
  logic [1:0] req;
  assign req       = {m1.cyc, m0.cyc};
  assign act       = state == ARB_OWN;
  assign g0        = act & ~own;
  assign g1        = act & own;
  assign gnt_o     = {g1, g0};
  assign timeout_o = act & to;
  assign o_cyc     = own ? m1.cyc : m0.cyc;
  assign o_stb     = own ? m1.stb : m0.stb;
  assign o_we      = own ? m1.we : m0.we;
  assign o_adr     = own ? m1.adr : m0.adr;
  assign o_dat     = own ? m1.dat_w : m0.dat_w;
  assign o_sel     = own ? m1.sel : m0.sel;
  assign oth_cyc   = own ? m0.cyc : m1.cyc;
  assign clr       = ~act | ~o_cyc | to;
  wb_outst_tracker #(.MAX_OUTST(MAX_OUTST), .TIMEOUT(TIMEOUT)) u_trk (
    .wb_clk_i,
    .wb_rst_i,
    .clr,
    .acc    (s.stb & ~s.stall),
    .rsp    (s.ack | s.err),
    .full,
    .rsp_ok,
    .to
  );
  // slave side mirrors the owner; request issue is throttled by the cap and the abort cycle
  always_comb begin
    s.cyc   = act & o_cyc;
    s.stb   = act & o_stb & ~full & ~to;
    s.we    = act & o_we;
    s.adr   = act ? o_adr : '0;
    s.dat_w = act ? o_dat : '0;
    s.sel   = act ? o_sel : '0;
  end
  // master side: only the owner sees slave responses, everyone else is stalled
  always_comb begin
    m0.stall = ~g0 | s.stall | full | to;
    m0.ack   = g0 & s.ack & rsp_ok & ~to;
    m0.err   = g0 & ((s.err & rsp_ok) | to);
    m0.dat_r = g0 ? s.dat_r : '0;
    m1.stall = ~g1 | s.stall | full | to;
    m1.ack   = g1 & s.ack & rsp_ok & ~to;
    m1.err   = g1 & ((s.err & rsp_ok) | to);
    m1.dat_r = g1 ? s.dat_r : '0;
  end
  // next owner: the requester other than the last one wins a tie; release hands off directly
  always_comb begin
    state_n = state;
    own_n   = own;
    last_n  = last;
    case (state)
      ARB_IDLE:
        if (|req) begin
          state_n = ARB_OWN;
          own_n   = &req ? ~last : req[1];
        end
      ARB_OWN:
        if (to) state_n = ARB_ABORT;
        else if (!o_cyc) begin
          last_n  = own;
          state_n = oth_cyc ? ARB_OWN : ARB_IDLE;
          own_n   = oth_cyc ? ~own : own;
        end
      ARB_ABORT: begin
        last_n  = own;
        state_n = |req ? ARB_OWN : ARB_IDLE;
        own_n   = &req ? ~own : req[1];
      end
      default: state_n = ARB_IDLE;
    endcase
  end
  // arbitration state register
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      state <= ARB_IDLE;
      own   <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_n;
      own   <= own_n;
      last  <= last_n;
    end
endmodule

// File: tb/tb_wb_arbiter_rr.sv
// tb_wb_arbiter_rr: directed stimulus with a per-cycle behavioural model and literal spot checks
module tb_wb_arbiter_rr;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] gnt;
  logic tout;
  int n_chk = 0;
  int n_err = 0;
  bit run = 1'b0;
  wb_arbiter_rr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
  wb_arbiter_rr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
  wb_arbiter_rr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();
  wb_arbiter_rr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(MO), .TIMEOUT(TO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m0       (m0_if),
    .m1       (m1_if),
    .s        (s_if),
    .gnt_o    (gnt),
    .timeout_o(tout)
  );
  always #5 clk = ~clk;
  logic [1:0] cyc_v, stb_v, we_v, stall_v, ack_v, err_v;
  logic [AW-1:0] adr_v [2];
  logic [DW-1:0] dw_v [2];
  logic [DW-1:0] dr_v [2];
  logic [DW/8-1:0] sel_v [2];
  assign cyc_v   = {m1_if.cyc, m0_if.cyc};
  assign stb_v   = {m1_if.stb, m0_if.stb};
  assign we_v    = {m1_if.we, m0_if.we};
  assign stall_v = {m1_if.stall, m0_if.stall};
  assign ack_v   = {m1_if.ack, m0_if.ack};
  assign err_v   = {m1_if.err, m0_if.err};
  assign adr_v[0] = m0_if.adr;
  assign adr_v[1] = m1_if.adr;
  assign dw_v[0]  = m0_if.dat_w;
  assign dw_v[1]  = m1_if.dat_w;
  assign dr_v[0]  = m0_if.dat_r;
  assign dr_v[1]  = m1_if.dat_r;
  assign sel_v[0] = m0_if.sel;
  assign sel_v[1] = m1_if.sel;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic tk();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input int i, input logic c, input logic st, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (i == 0) begin
      m0_if.cyc = c; m0_if.stb = st; m0_if.we = w; m0_if.adr = a; m0_if.dat_w = d; m0_if.sel = '1;
    end else begin
      m1_if.cyc = c; m1_if.stb = st; m1_if.we = w; m1_if.adr = a; m1_if.dat_w = d; m1_if.sel = '1;
    end
  endtask
  task automatic slv(input logic st, input logic ak, input logic er, input logic [DW-1:0] d);
    s_if.stall = st; s_if.ack = ak; s_if.err = er; s_if.dat_r = d;
  endtask
  // model: who owns the bus (-1 none), who owned it last, requests in flight, cycles since last accept/ack
  int own_m = -1, last_m = 1, out_m = 0, since_m = 0, o, acc, rv;
  bit ab_m = 1'b0, on, full, fire, e_stb, mine;
  function automatic int pick(input int l);
    return (&cyc_v) ? 1 - l : cyc_v[0] ? 0 : cyc_v[1] ? 1 : -1;
  endfunction
  // compare every DUT output against the model, then advance the model by one cycle
  always @(negedge clk) if (run) begin
    on    = !ab_m && own_m >= 0;
    o     = on ? own_m : 0;
    full  = out_m == MO;
    fire  = on && TO > 0 && out_m > 0 && since_m == TO;
    e_stb = on && stb_v[o] && !full && !fire;
    chk("s_cyc", s_if.cyc, on && cyc_v[o]);
    chk("s_stb", s_if.stb, e_stb);
    chk("s_we", s_if.we, on && we_v[o]);
    chk("s_adr", s_if.adr, on ? adr_v[o] : 0);
    chk("s_dat", s_if.dat_w, on ? dw_v[o] : 0);
    chk("s_sel", s_if.sel, on ? sel_v[o] : 0);
    chk("gnt", gnt, on ? 2'(1 << o) : 2'b00);
    chk("timeout", tout, fire);
    rv = ((s_if.ack || s_if.err) && out_m > 0) ? 1 : 0;
    for (int i = 0; i < 2; i++) begin
      mine = on && o == i;
      chk($sformatf("m%0d_stall", i), stall_v[i], !mine || s_if.stall || full || fire);
      chk($sformatf("m%0d_ack", i), ack_v[i], mine && s_if.ack && out_m > 0 && !fire);
      chk($sformatf("m%0d_err", i), err_v[i], mine && ((s_if.err && out_m > 0) || fire));
      chk($sformatf("m%0d_dat", i), dr_v[i], mine ? s_if.dat_r : 0);
    end
    acc = (e_stb && !s_if.stall) ? 1 : 0;
    if (rst) begin
      own_m = -1; last_m = 1; out_m = 0; ab_m = 0;
    end else if (ab_m) begin
      ab_m = 0; last_m = own_m; own_m = pick(own_m);
    end else if (own_m < 0) own_m = pick(last_m);
    else if (fire) begin
      ab_m = 1; out_m = 0;
    end else if (!cyc_v[o]) begin
      last_m = o; own_m = cyc_v[1-o] ? 1 - o : -1; out_m = 0;
    end else begin
      out_m   = out_m + acc - rv;
      since_m = (acc != 0 || rv != 0) ? 1 : since_m + 1;
    end
  end
  int iss;
  logic [12:0] ap;
  // directed scenarios with hand-computed spot checks
  initial begin
    drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0); slv(0, 0, 0, 0);
    tk(); run = 1; tk(); rst = 0; tk();
    drv(0, 1, 1, 0, 32'h100, 0); #1;
    chk("t1_gnt_idle", gnt, 2'b00); tk();
    #1; chk("t1_gnt", gnt, 2'b01); chk("t1_stb", s_if.stb, 1); chk("t1_adr", s_if.adr, 32'h100); tk();
    drv(0, 1, 0, 0, 32'h100, 0); tk();
    slv(0, 1, 0, 32'hDEADBEEF); #1;
    chk("t1_ack", m0_if.ack, 1); chk("t1_dat", m0_if.dat_r, 32'hDEADBEEF); chk("t1_m1_stall", m1_if.stall, 1); tk();
    slv(0, 0, 0, 0); drv(0, 0, 0, 0, 0, 0); tk();
    #1; chk("t1_gnt_rel", gnt, 2'b00);
    rst = 1; tk(); rst = 0;
    drv(0, 1, 0, 0, 0, 0); drv(1, 1, 0, 0, 32'h10, 0); tk();
    drv(0, 0, 0, 0, 0, 0); #1; chk("t2_first", gnt, 2'b01); tk();
    drv(0, 1, 0, 0, 0, 0); #1; chk("t2_second", gnt, 2'b10); chk("t2_scyc", s_if.cyc, 1); tk();
    drv(1, 0, 0, 0, 0, 0); tk();
    drv(0, 0, 0, 0, 0, 0); drv(1, 1, 0, 0, 0, 0); #1; chk("t2_third", gnt, 2'b01); tk();
    drv(1, 0, 0, 0, 0, 0); #1; chk("t2_fourth", gnt, 2'b10); tk();
    drv(0, 1, 0, 0, 0, 0); drv(1, 1, 0, 0, 0, 0); #1; chk("t2_gap", gnt, 2'b00); tk();
    drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0); #1; chk("t2_again", gnt, 2'b01); tk();
    drv(0, 1, 1, 1, 32'h200, 0); tk();
    iss = 0; ap = 13'b0_1111_0101_0000;
    for (int k = 0; k < 13; k++) begin
      drv(0, 1, iss < 6, 1, 32'h200 + 32'(iss * 4), 32'(iss)); slv(0, ap[k], 0, 0); #1;
      if (k == 4) begin
        chk("t3_accepted", 32'(iss), 4); chk("t3_full_stall", m0_if.stall, 1); chk("t3_full_stb", s_if.stb, 0);
      end
      if (k == 5) chk("t3_slot", m0_if.stall, 0);
      if (m0_if.stb && !m0_if.stall) iss++;
      tk();
    end
    chk("t3_total", 32'(iss), 6);
    drv(0, 0, 0, 0, 0, 0); slv(0, 0, 0, 0); tk();
    drv(0, 1, 1, 0, 32'h300, 0); tk();
    #1; chk("t4_gnt", gnt, 2'b01); tk();
    drv(0, 1, 0, 0, 32'h300, 0); drv(1, 1, 0, 0, 32'h400, 0);
    repeat (6) tk();
    #1; chk("t4_early", tout, 0); tk();
    #1; chk("t4_pulse", tout, 1); chk("t4_err", m0_if.err, 1); chk("t4_scyc", s_if.cyc, 1); tk();
    #1; chk("t4_abort_cyc", s_if.cyc, 0); chk("t4_abort_gnt", gnt, 2'b00); chk("t4_abort_to", tout, 0); tk();
    slv(0, 1, 0, 32'h55); #1; chk("t4_m1", gnt, 2'b10); chk("t5_spur", m1_if.ack, 0); tk();
    drv(1, 1, 1, 0, 32'h404, 0); slv(0, 0, 0, 0); tk();
    slv(0, 1, 0, 32'h66); #1; chk("t5_both", m1_if.ack, 1); tk();
    drv(1, 1, 0, 0, 32'h404, 0); #1; chk("t5_last", m1_if.ack, 1); tk();
    #1; chk("t5_empty", m1_if.ack, 0); tk();
    slv(0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0); tk();
    drv(0, 1, 1, 1, 32'h500, 32'h11); #1; chk("t6_gnt", gnt, 2'b01); tk();
    tk(); tk();
    drv(0, 1, 0, 1, 32'h500, 0); rst = 1; #1; chk("t6_pre", gnt, 2'b01); tk();
    rst = 0; slv(0, 1, 0, 32'h77); #1;
    chk("t6_gnt0", gnt, 2'b00); chk("t6_scyc", s_if.cyc, 0); chk("t6_ack", m0_if.ack, 0); tk();
    #1; chk("t6_regnt", gnt, 2'b01); chk("t6_late", m0_if.ack, 0); tk();
    drv(0, 0, 0, 0, 0, 0); slv(0, 0, 0, 0); tk(); tk();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
